// File: rtl/avalon_vga_rect_fill.sv
// Rectangle-fill engine: CPU programs corners/colour over a small Avalon slave,
// then the engine streams one 8-bit pixel write per frame-buffer address.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start; slave registers freely writable
// S_SETUP  | latch clamped corners/colour, compute first row base
// S_WRITE  | master write held high, advances x/y on each accepted pixel
// S_FINISH | one cycle, sets done and returns to idle
module avalon_vga_rect_fill #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [1:0]  i_address,
    input  logic        i_chipselect,
    input  logic        i_read,
    input  logic        i_write,
    input  logic [31:0] i_writedata,
    output logic [31:0] o_readdata,
    output logic [19:0] o_m_address,
    output logic        o_m_write,
    output logic [31:0] o_m_writedata,
    input  logic        i_m_waitrequest,
    output logic        o_irq
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_WRITE  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [9:0]  X_MAX      = 10'(H_RES - 1);
    localparam logic [9:0]  Y_MAX      = 10'(V_RES - 1);
    localparam logic [18:0] ROW_STRIDE = 19'(H_RES);

    state_t state, state_nxt;

    logic [9:0]  reg_x0, reg_x1, reg_y0, reg_y1;
    logic [7:0]  reg_colour;
    logic        irq_en;
    logic        done;

    logic [9:0]  cur_x, cur_y;
    logic [9:0]  lat_x0, lat_x1, lat_y1;
    logic [7:0]  lat_colour;
    logic [18:0] row_base;
    logic        abort_pend;

    logic        wr_sel, wr_x, wr_y, wr_colour, wr_ctrl;
    logic        start_req, abort_req, clear_req;
    logic        busy, accept, x_more, y_more;
    logic [9:0]  cx0, cx1, cy0, cy1;
    logic        rect_empty;
    logic [18:0] y0_ext, row_base_init;
    logic        unused_wdata;

    // Slave write decode
    assign wr_sel    = i_chipselect & i_write;
    assign wr_x      = wr_sel & (i_address == 2'd0);
    assign wr_y      = wr_sel & (i_address == 2'd1);
    assign wr_colour = wr_sel & (i_address == 2'd2);
    assign wr_ctrl   = wr_sel & (i_address == 2'd3);
    assign start_req = wr_ctrl & i_writedata[0];
    assign abort_req = wr_ctrl & i_writedata[1];
    assign clear_req = wr_ctrl & i_writedata[3];

    assign unused_wdata = ^{i_writedata[31:26], i_writedata[15:10]};

    assign cx0 = (reg_x0 > X_MAX) ? X_MAX : reg_x0;
    assign cx1 = (reg_x1 > X_MAX) ? X_MAX : reg_x1;
    assign cy0 = (reg_y0 > Y_MAX) ? Y_MAX : reg_y0;
    assign cy1 = (reg_y1 > Y_MAX) ? Y_MAX : reg_y1;
    assign rect_empty = (cx0 > cx1) | (cy0 > cy1);

    // y0*640 as shift-add; 479*640 still fits in 19 bits
    assign y0_ext        = {9'b0, cy0};
    assign row_base_init = (y0_ext << 9) + (y0_ext << 7);

    assign busy   = (state != S_IDLE);
    assign accept = (state == S_WRITE) & ~i_m_waitrequest;
    assign x_more = (cur_x < lat_x1);
    assign y_more = (cur_y < lat_y1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_req) state_nxt = S_SETUP;
            end
            S_SETUP: begin
                if (abort_req || rect_empty) state_nxt = S_FINISH;
                else                         state_nxt = S_WRITE;
            end
            S_WRITE: begin
                // The pending write must complete before an abort takes effect
                if (accept) begin
                    if (abort_req || abort_pend)  state_nxt = S_FINISH;
                    else if (!x_more && !y_more)  state_nxt = S_FINISH;
                end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_m_write     = 1'b0;
        o_m_address   = 20'd0;
        o_m_writedata = 32'd0;
        if (state == S_WRITE) begin
            o_m_write     = 1'b1;
            o_m_address   = {1'b0, row_base + {9'b0, cur_x}};
            o_m_writedata = {24'b0, lat_colour};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            reg_x0     <= '0;
            reg_x1     <= '0;
            reg_y0     <= '0;
            reg_y1     <= '0;
            reg_colour <= '0;
            irq_en     <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (wr_x) begin
                reg_x0 <= i_writedata[9:0];
                reg_x1 <= i_writedata[25:16];
            end
            if (wr_y) begin
                reg_y0 <= i_writedata[9:0];
                reg_y1 <= i_writedata[25:16];
            end
            if (wr_colour) reg_colour <= i_writedata[7:0];
            if (wr_ctrl)   irq_en     <= i_writedata[2];
            // Setting done on FINISH beats a simultaneous clear
            if (state == S_FINISH)
                done <= 1'b1;
            else if (clear_req || (state == S_IDLE && start_req))
                done <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cur_x      <= '0;
            cur_y      <= '0;
            lat_x0     <= '0;
            lat_x1     <= '0;
            lat_y1     <= '0;
            lat_colour <= '0;
            row_base   <= '0;
            abort_pend <= 1'b0;
        end else begin
            case (state)
                S_SETUP: begin
                    lat_x0     <= cx0;
                    lat_x1     <= cx1;
                    lat_y1     <= cy1;
                    lat_colour <= reg_colour;
                    cur_x      <= cx0;
                    cur_y      <= cy0;
                    row_base   <= row_base_init;
                    abort_pend <= 1'b0;
                end
                S_WRITE: begin
                    if (abort_req) abort_pend <= 1'b1;
                    if (accept) begin
                        if (x_more) begin
                            cur_x <= cur_x + 10'd1;
                        end else if (y_more) begin
                            cur_x    <= lat_x0;
                            cur_y    <= cur_y + 10'd1;
                            row_base <= row_base + ROW_STRIDE;
                        end
                    end
                end
                default: abort_pend <= 1'b0;
            endcase
        end
    end

    always_comb begin
        o_readdata = 32'd0;
        if (i_chipselect && i_read) begin
            case (i_address)
                2'd0:    o_readdata = {6'b0, reg_x1, 6'b0, reg_x0};
                2'd1:    o_readdata = {6'b0, reg_y1, 6'b0, reg_y0};
                2'd2:    o_readdata = {24'b0, reg_colour};
                default: o_readdata = {29'b0, irq_en, done, busy};
            endcase
        end
    end

    assign o_irq = done & irq_en;

endmodule

// File: doc/avalon_vga_rect_fill.md
# avalon_vga_rect_fill

Avalon-MM rectangle-fill engine that sits directly upstream of the Avalon VGA frame-buffer slave. The CPU programs corners and colour through a small slave register port and starts the engine. The engine then acts as a write-only Avalon-MM master and streams one 8-bit pixel write per frame-buffer address (`y*640 + x`) into the VGA slave's SRAM window. This offloads bulk fills (clear screen, boxes) from the processor.

## Interface
- `H_RES`, 640: pixels per line; also the row stride of the frame-buffer address.
- `V_RES`, 480: lines per frame.
- `i_clk` in 1: single clock, shared with the CPU/Avalon fabric.
- `i_reset` in 1: reset, synchronous and active-high.
- `i_address` in 2: slave word address (register select).
- `i_chipselect` in 1: slave select.
- `i_read` in 1: slave read strobe.
- `i_write` in 1: slave write strobe.
- `i_writedata` in 32: slave write data.
- `o_readdata` out 32: slave read data.
- `o_m_address` out 20: master address; bit 19 is always 0, which selects the VRAM window downstream.
- `o_m_write` out 1: master write request.
- `o_m_writedata` out 32: master write data, `{24'b0, colour}`.
- `i_m_waitrequest` in 1: downstream stall.
- `o_irq` out 1: level interrupt, equal to `done & irq_en`.

## Operation
- Register map (`i_address`):
  - 0 X: [9:0] = x0, [25:16] = x1.
  - 1 Y: [9:0] = y0, [25:16] = y1.
  - 2 COLOUR: [7:0].
  - 3 CTRL.
    - Write: bit0 start, bit1 abort, bit2 irq_en (stored), bit3 clear_done.
    - Read: bit0 busy, bit1 done, bit2 irq_en.
- Slave timing:
  - Zero wait states.
  - Read latency 0: `o_readdata` is combinational on `i_address` whenever `i_chipselect & i_read`, and 0 otherwise.
  - Unused bits read 0.
- Writes to X, Y and COLOUR while busy are accepted. They take effect on the next start, because the engine latches all parameters in SETUP.
- Clamping in SETUP: any x above `H_RES-1` becomes `H_RES-1`; any y above `V_RES-1` becomes `V_RES-1`.
- Empty rectangle: if clamped x0 > x1 or y0 > y1, the engine issues zero writes and goes SETUP→FINISH.
- FSM:
  - **IDLE**: start → SETUP. start also clears done.
  - **SETUP** (1 cycle):
    - Latch the clamped coordinates and colour.
    - `row_base = y0*640`, computed as `(y0<<9)+(y0<<7)`.
    - `x = x0`, `y = y0`.
    - → WRITE, or → FINISH if the rectangle is empty.
  - **WRITE**:
    - Drive `o_m_write=1` and `o_m_address = row_base + x` (19-bit sum, zero-extended).
    - On a cycle where `~i_m_waitrequest`, the pixel is accepted:
      - If x < x1: `x++`.
      - Else if y < y1: `x = x0`, `y++`, `row_base += 640`.
      - Else → FINISH.
  - **FINISH** (1 cycle): set done, → IDLE.
- busy = (state != IDLE).
- Maximum address is 479*640 + 639 = 307199, which fits in 19 bits with no overflow.
- start while busy is ignored.
- abort:
  - In IDLE it is a no-op.
  - In SETUP → FINISH.
  - In WRITE, the current write is held until accepted (Avalon rule), then → FINISH with no further writes.
- Simultaneous start and abort in IDLE: start wins, and abort is ignored.
- clear_done in the same cycle as the FINISH→done set: set wins.
- Reset: on the next edge, state = IDLE and all registers = 0. `o_m_write` drops even mid-burst, since downstream shares the reset.

## Timing
- Reset values:
  - `o_m_write = 0`, `o_m_address = 0`, `o_m_writedata = 0`.
  - `o_irq = 0`, `o_readdata = 0`.
  - busy = 0, done = 0, irq_en = 0.
- CTRL start written at edge N:
  - State is SETUP after N.
  - `o_m_write` is high after edge N+1.
  - The first accepted write occurs at edge N+2 if there is no wait.
- Throughput is 1 pixel per cycle when `i_m_waitrequest = 0`. There are no bubbles at row wrap.
- `o_m_address` and `o_m_writedata` are stable throughout any `waitrequest` stall.
- The last accepted write at edge M gives FINISH after M, then done = 1 and busy = 0 after M+1. `o_irq` rises in the same cycle as done.
- Fill duration with no stalls is W*H + 2 cycles from the start edge to done.

## Test plan
- Reset mid-fill: assert `i_reset` during WRITE → the next cycle shows `o_m_write = 0` and CTRL reads 0; a new start then runs normally.
- 1×1 fill: X=0x00050005, Y=0x00030003, COLOUR=0xE0, start → exactly one write to address 1925 with data 0xE0; done at start+3 cycles.
- 3×2 fill with random waitrequest: x 10..12, y 1..2 → writes in order to addresses 650, 651, 652, 1290, 1291, 1292. Address and data are held during every stall, and exactly 6 handshakes occur.
- Clamp and empty:
  - X=0x03FF0280, Y=0x01DF01DF → a single write at 307199.
  - x0=5, x1=4 → zero writes, done set 2 cycles after start.
- Abort during a stall: abort while `waitrequest = 1` mid-row → the write is held until accepted, no further writes follow, done = 1, and `o_irq = 1` when irq_en is set.
- Register semantics: start while busy → no restart and the write count is unchanged; clear_done → done = 0 and `o_irq` falls; readback of X/Y/COLOUR matches the written values.
